// File: rtl/fpcvt_pkg.sv
// Shared types and helpers for the sequential two's-complement to float converter.
// Holds the FSM encoding, derived widths and the half-up round/saturate step.
package fpcvt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

    function automatic int mag_w(input int in_w);
        return in_w - 1;
    endfunction

    function automatic int e_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Round half-up on the kept bits, carry into the exponent, clamp past e_max.
    function automatic void round_step(
        input  int   sig_w,
        input  int   emax,
        input  int   low,
        input  logic rbit,
        input  int   e_in,
        output int   f,
        output int   e_out,
        output logic sat
    );
        f     = low + int'(rbit);
        e_out = e_in;
        sat   = 1'b0;
        if (f == (1 << sig_w)) begin
            f     = 1 << (sig_w - 1);
            e_out = e_in + 1;
        end
        if (e_out > emax) begin
            f     = (1 << sig_w) - 1;
            e_out = emax;
            sat   = 1'b1;
        end
    endfunction

endpackage

// File: rtl/fp_convert_seq_round.sv
// Combinational rounding stage: kept significand bits plus round bit
// become the final significand, exponent and saturation flag.
module fp_round
    import fpcvt_pkg::*;
#(
    parameter int EXP_W = 3,
    parameter int SIG_W = 4
) (
    input  logic [SIG_W-1:0] mag,
    input  logic             rbit,
    input  logic [EXP_W:0]   e,
    input  logic             sat_pend,
    output logic [SIG_W-1:0] f,
    output logic [EXP_W-1:0] e_out,
    output logic             sat
);

    int   f_i;
    int   e_i;
    logic s_i;

    always_comb begin
        f_i = 0;
        e_i = 0;
        s_i = 1'b0;
        round_step(SIG_W, e_max(EXP_W), int'(mag), rbit, int'(e), f_i, e_i, s_i);
        f     = SIG_W'(f_i);
        e_out = EXP_W'(e_i);
        sat   = s_i | sat_pend;
    end

endmodule

// File: rtl/fp_convert_seq.sv
// Sequential two's-complement to small float converter with valid/ready on
// both sides; normalises one right-shift per cycle, then rounds in one cycle.
module fp_convert_seq
    import fpcvt_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int SIG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [SIG_W-1:0] out_sig,
    output logic             out_sat
);

    localparam int MAG_W = mag_w(IN_W);
    localparam int E_MAX = e_max(EXP_W);

    generate
        if ((MAG_W - SIG_W > E_MAX) || (SIG_W < 2)) begin : g_bad_cfg
            $fatal(1, "fp_convert_seq: unsupported IN_W/EXP_W/SIG_W combination");
        end
    endgenerate

    state_t           state;
    logic [MAG_W-1:0] mag;
    logic [EXP_W:0]   e;
    logic             rbit;
    logic             sat_pend;
    logic             sign_q;

    logic [MAG_W-1:0] low_bits;
    logic [MAG_W-1:0] neg_low;
    logic             in_neg;
    logic             in_min;
    logic [MAG_W-1:0] abs_in;

    logic [SIG_W-1:0] f_r;
    logic [EXP_W-1:0] e_r;
    logic             sat_r;

    // Only the most negative word has zero low bits with the sign set.
    always_comb begin
        low_bits = in_data[MAG_W-1:0];
        in_neg   = in_data[IN_W-1];
        neg_low  = ~low_bits + MAG_W'(1);
        in_min   = in_neg && (low_bits == '0);
        abs_in   = low_bits;
        if (in_min) begin
            abs_in = '1;
        end else if (in_neg) begin
            abs_in = neg_low;
        end
    end

    fp_round #(
        .EXP_W(EXP_W),
        .SIG_W(SIG_W)
    ) u_round (
        .mag     (mag[SIG_W-1:0]),
        .rbit    (rbit),
        .e       (e),
        .sat_pend(sat_pend),
        .f       (f_r),
        .e_out   (e_r),
        .sat     (sat_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_sig   <= '0;
            out_sat   <= 1'b0;
            mag       <= '0;
            e         <= '0;
            rbit      <= 1'b0;
            sat_pend  <= 1'b0;
            sign_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sign_q   <= in_neg;
                        mag      <= abs_in;
                        e        <= '0;
                        rbit     <= 1'b0;
                        sat_pend <= in_min;
                        in_ready <= 1'b0;
                        state    <= NORM;
                    end
                end
                NORM: begin
                    if (|mag[MAG_W-1:SIG_W]) begin
                        mag  <= mag >> 1;
                        rbit <= mag[0];
                        e    <= e + (EXP_W+1)'(1);
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    out_sign  <= sign_q;
                    out_exp   <= e_r;
                    out_sig   <= f_r;
                    out_sat   <= sat_r;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_convert_seq.sv
// Directed bench for fp_convert_seq: vector table with hand-computed results
// plus backpressure and mid-operation reset sequences.
module tb_fp_convert_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [2:0]  out_exp;
    logic [3:0]  out_sig;
    logic        out_sat;

    int errors = 0;
    int checks = 0;

    fp_convert_seq #(
        .IN_W (12),
        .EXP_W(3),
        .SIG_W(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sign (out_sign),
        .out_exp  (out_exp),
        .out_sig  (out_sig),
        .out_sat  (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] din;
        logic        sign;
        logic [2:0]  exp;
        logic [3:0]  sig;
        logic        sat;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        bit seen;
        chk($sformatf("v%0d_in_ready", idx), int'(in_ready), 1);
        in_data  = v.din;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = 1'b0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                n = i;
                seen = 1'b1;
                break;
            end
        end
        chk($sformatf("v%0d_valid_seen", idx), int'(seen), 1);
        if (seen) begin
            chk($sformatf("v%0d_latency", idx), n, v.lat);
            chk($sformatf("v%0d_sign", idx), int'(out_sign), int'(v.sign));
            chk($sformatf("v%0d_exp", idx), int'(out_exp), int'(v.exp));
            chk($sformatf("v%0d_sig", idx), int'(out_sig), int'(v.sig));
            chk($sformatf("v%0d_sat", idx), int'(out_sat), int'(v.sat));
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_valid_clear", idx), int'(out_valid), 0);
    endtask

    initial begin
        bit seen;
        bit any;

        // din, sign, exp, sig, sat, latency (k+2)
        vecs[0]  = '{12'd422,  1'b0, 3'd5, 4'd13, 1'b0, 7};
        vecs[1]  = '{12'hE5A,  1'b1, 3'd5, 4'd13, 1'b0, 7};
        vecs[2]  = '{12'd0,    1'b0, 3'd0, 4'd0,  1'b0, 2};
        vecs[3]  = '{12'd124,  1'b0, 3'd4, 4'd8,  1'b0, 5};
        vecs[4]  = '{12'd7,    1'b0, 3'd0, 4'd7,  1'b0, 2};
        vecs[5]  = '{12'd2047, 1'b0, 3'd7, 4'd15, 1'b1, 9};
        vecs[6]  = '{12'h800,  1'b1, 3'd7, 4'd15, 1'b1, 9};
        // 1984 = 15.5 * 128 rounds up past E_MAX; 1920 = 15 * 128 is exact
        vecs[7]  = '{12'd1984, 1'b0, 3'd7, 4'd15, 1'b1, 9};
        vecs[8]  = '{12'd1920, 1'b0, 3'd7, 4'd15, 1'b0, 9};
        vecs[9]  = '{12'd15,   1'b0, 3'd0, 4'd15, 1'b0, 2};
        vecs[10] = '{12'd16,   1'b0, 3'd1, 4'd8,  1'b0, 3};
        vecs[11] = '{12'hFFF,  1'b1, 3'd0, 4'd1,  1'b0, 2};
        vecs[12] = '{12'd23,   1'b0, 3'd1, 4'd12, 1'b0, 3};
        vecs[13] = '{12'd31,   1'b0, 3'd2, 4'd8,  1'b0, 3};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sign", int'(out_sign), 0);
        chk("rst_out_exp", int'(out_exp), 0);
        chk("rst_out_sig", int'(out_sig), 0);
        chk("rst_out_sat", int'(out_sat), 0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Backpressure: result must hold and new words must be refused.
        out_ready = 1'b0;
        in_data   = 12'd422;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("hold_valid_seen", int'(seen), 1);
        for (int c = 0; c < 5; c++) begin
            in_data  = 12'd7;
            in_valid = (c % 2) == 0;
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_valid", c), int'(out_valid), 1);
            chk($sformatf("hold%0d_in_ready", c), int'(in_ready), 0);
            chk($sformatf("hold%0d_exp", c), int'(out_exp), 5);
            chk($sformatf("hold%0d_sig", c), int'(out_sig), 13);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release_valid", int'(out_valid), 0);
        chk("hold_release_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        chk("idle_held_sig", int'(out_sig), 13);
        chk("idle_held_exp", int'(out_exp), 5);
        chk("idle_no_valid", int'(out_valid), 0);

        // Reset while normalising aborts the conversion.
        in_data  = 12'd2047;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("norm_in_ready", int'(in_ready), 0);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_sig", int'(out_sig), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        any = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) any = 1'b1;
        end
        chk("abort_no_result", int'(any), 0);

        run_vec(vecs[4], 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
